// File: rtl/pmu_pkg.sv
// ---------------------------------------------------------------------------
// pmu_pkg
//   Shared definitions for the multi-counter performance monitor.
//   - EVT_* : bit positions of the pipeline event strobes on pmu_multi.evt
//   - pmu_cfg_t : per-counter configuration word (event select, enable,
//     saturate/wrap mode, overflow interrupt enable)
// ---------------------------------------------------------------------------
package pmu_pkg;

    localparam int unsigned EVT_RETIRE   = 0;
    localparam int unsigned EVT_STALL    = 1;
    localparam int unsigned EVT_FLUSH    = 2;
    localparam int unsigned EVT_DM_RD    = 3;
    localparam int unsigned EVT_DM_WR    = 4;
    localparam int unsigned EVT_BRANCH   = 5;
    localparam int unsigned EVT_LOAD_USE = 6;
    localparam int unsigned EVT_RSVD     = 7;

    // Widest event select the config word can carry (up to 256 events).
    localparam int unsigned PMU_SEL_W_MAX = 8;

    typedef struct packed {
        logic [PMU_SEL_W_MAX-1:0] sel;
        logic                     en;
        logic                     sat;
        logic                     irq_en;
    } pmu_cfg_t;

endpackage

// File: rtl/pmu_counter.sv
// ---------------------------------------------------------------------------
// pmu_counter
//   One programmable event counter with its configuration register,
//   wrap/saturate mode and sticky overflow.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     evt          event strobes (NUM_EVT)
//     cfg_we       configuration write already decoded for this counter
//     cfg_in       configuration word to load on cfg_we
//     clr          clear value and overflow
//     freeze       hold value
//     value        live count (registered)
//     ovf          sticky overflow (registered)
//     irq_pend     ovf qualified by the configured interrupt enable
//     value_next   value being written at the coming edge (for snapshot)
// ---------------------------------------------------------------------------
module pmu_counter
    import pmu_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               cfg_we,
    input  pmu_cfg_t           cfg_in,
    input  logic               clr,
    input  logic               freeze,
    output logic [CNT_W-1:0]   value,
    output logic               ovf,
    output logic               irq_pend,
    output logic [CNT_W-1:0]   value_next
);

    localparam int unsigned SEL_W     = $clog2(NUM_EVT);
    localparam int unsigned EVT_PAD_W = 1 << SEL_W;

    pmu_cfg_t               cfg_q, cfg_d;
    logic [CNT_W-1:0]       val_q, val_d;
    logic                   ovf_q, ovf_d;
    logic [EVT_PAD_W-1:0]   evt_pad;
    logic                   sel_oob;
    logic                   hit;

    // Selects beyond NUM_EVT land on zero padding or above the select
    // width, so they never count.
    assign evt_pad = EVT_PAD_W'(evt);
    assign sel_oob = |(cfg_q.sel >> SEL_W);
    assign hit     = cfg_q.en & ~sel_oob & evt_pad[cfg_q.sel[SEL_W-1:0]];

    always_comb begin
        cfg_d = cfg_q;
        val_d = val_q;
        ovf_d = ovf_q;
        if (cfg_we) begin
            cfg_d = cfg_in;
            val_d = '0;
            ovf_d = 1'b0;
        end else if (clr) begin
            val_d = '0;
            ovf_d = 1'b0;
        end else if (!freeze && hit) begin
            if (val_q == '1) begin
                ovf_d = 1'b1;
                val_d = cfg_q.sat ? val_q : '0;
            end else begin
                val_d = val_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= '0;
            val_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            val_q <= val_d;
            ovf_q <= ovf_d;
        end
    end

    assign value      = val_q;
    assign ovf        = ovf_q;
    assign irq_pend   = ovf_q & cfg_q.irq_en;
    assign value_next = val_d;

endmodule

// File: rtl/pmu_multi.sv
// ---------------------------------------------------------------------------
// pmu_multi
//   Performance monitor: free-running cycle counter plus NUM_CNT
//   programmable event counters with snapshot shadow and registered read.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     evt             pipeline event strobes (see pmu_pkg EVT_*)
//     cfg_we/cfg_idx  configuration write to counter cfg_idx with
//     cfg_sel/cfg_en  event select, enable,
//     cfg_sat         saturate (1) or wrap (0),
//     cfg_irq_en      overflow interrupt enable
//     clr             per-counter clear of value and overflow
//     freeze          hold every counter including cycle_count
//     snap_req        copy live counters into the shadow
//     snap_valid      shadow holds a snapshot
//     rd_idx          read select
//     rd_shadow       read shadow (1) or live (0)
//     rd_data/rd_ovf  registered read data and live sticky overflow
//     cycle_count     live cycle counter
//     ovf_irq         registered OR of enabled overflows
// ---------------------------------------------------------------------------
module pmu_multi
    import pmu_pkg::*;
#(
    parameter int unsigned NUM_CNT = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned CYC_W   = 48,
    parameter int unsigned NUM_EVT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_EVT-1:0]         evt,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CNT)-1:0] cfg_idx,
    input  logic [$clog2(NUM_EVT)-1:0] cfg_sel,
    input  logic                       cfg_en,
    input  logic                       cfg_sat,
    input  logic                       cfg_irq_en,
    input  logic [NUM_CNT-1:0]         clr,
    input  logic                       freeze,
    input  logic                       snap_req,
    output logic                       snap_valid,
    input  logic [$clog2(NUM_CNT)-1:0] rd_idx,
    input  logic                       rd_shadow,
    output logic [CNT_W-1:0]           rd_data,
    output logic                       rd_ovf,
    output logic [CYC_W-1:0]           cycle_count,
    output logic                       ovf_irq
);

    localparam int unsigned IDX_W = $clog2(NUM_CNT);

    pmu_cfg_t           cfg_in;
    logic [CNT_W-1:0]   cnt_val  [NUM_CNT];
    logic [CNT_W-1:0]   cnt_next [NUM_CNT];
    logic [CNT_W-1:0]   shadow   [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_ovf;
    logic [NUM_CNT-1:0] irq_pend;
    logic [CNT_W-1:0]   rd_data_d;
    logic               rd_ovf_d;

    always_comb begin
        cfg_in        = '0;
        cfg_in.sel    = PMU_SEL_W_MAX'(cfg_sel);
        cfg_in.en     = cfg_en;
        cfg_in.sat    = cfg_sat;
        cfg_in.irq_en = cfg_irq_en;
    end

    // Indices >= NUM_CNT decode to no counter, so such writes are dropped.
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        pmu_counter #(
            .CNT_W   (CNT_W),
            .NUM_EVT (NUM_EVT)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .evt        (evt),
            .cfg_we     (cfg_we && (cfg_idx == IDX_W'(i))),
            .cfg_in     (cfg_in),
            .clr        (clr[i]),
            .freeze     (freeze),
            .value      (cnt_val[i]),
            .ovf        (cnt_ovf[i]),
            .irq_pend   (irq_pend[i]),
            .value_next (cnt_next[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (!freeze) begin
            cycle_count <= cycle_count + CYC_W'(1);
        end
    end

    // Shadow captures the post-edge values so a coincident event is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_valid <= 1'b0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap_req) begin
            snap_valid <= 1'b1;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                shadow[i] <= cnt_next[i];
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_ovf_d = cnt_ovf[i];
                if (!rd_shadow) begin
                    rd_data_d = cnt_val[i];
                end else if (snap_valid) begin
                    rd_data_d = shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_ovf  <= 1'b0;
            ovf_irq <= 1'b0;
        end else begin
            rd_data <= rd_data_d;
            rd_ovf  <= rd_ovf_d;
            ovf_irq <= |irq_pend;
        end
    end

endmodule

// File: tb/tb_pmu_multi.sv
module tb_pmu_multi;
    import pmu_pkg::*;

    localparam int unsigned NC    = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned YW    = 48;
    localparam int unsigned NE    = 8;
    localparam int unsigned CMAX  = (1 << CW) - 1;
    localparam longint unsigned CYC_MASK = (64'd1 << YW) - 1;

    logic           clk;
    logic           rst;
    logic [NE-1:0]  evt;
    logic           cfg_we;
    logic [1:0]     cfg_idx;
    logic [2:0]     cfg_sel;
    logic           cfg_en;
    logic           cfg_sat;
    logic           cfg_irq_en;
    logic [NC-1:0]  clr;
    logic           freeze;
    logic           snap_req;
    logic           snap_valid;
    logic [1:0]     rd_idx;
    logic           rd_shadow;
    logic [CW-1:0]  rd_data;
    logic           rd_ovf;
    logic [YW-1:0]  cycle_count;
    logic           ovf_irq;

    pmu_multi #(
        .NUM_CNT (NC),
        .CNT_W   (CW),
        .CYC_W   (YW),
        .NUM_EVT (NE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .evt         (evt),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_sel     (cfg_sel),
        .cfg_en      (cfg_en),
        .cfg_sat     (cfg_sat),
        .cfg_irq_en  (cfg_irq_en),
        .clr         (clr),
        .freeze      (freeze),
        .snap_req    (snap_req),
        .snap_valid  (snap_valid),
        .rd_idx      (rd_idx),
        .rd_shadow   (rd_shadow),
        .rd_data     (rd_data),
        .rd_ovf      (rd_ovf),
        .cycle_count (cycle_count),
        .ovf_irq     (ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer state per counter.
    int unsigned     m_val    [NC];
    bit              m_ovf    [NC];
    int unsigned     m_sel    [NC];
    bit              m_en     [NC];
    bit              m_sat    [NC];
    bit              m_irq_en [NC];
    int unsigned     m_shadow [NC];
    bit              m_snapv;
    longint unsigned m_cyc;
    int unsigned     m_rd_data;
    bit              m_rd_ovf;
    bit              m_irq;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int unsigned idx;
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                m_val[i] = 0; m_ovf[i] = 0; m_sel[i] = 0; m_en[i] = 0;
                m_sat[i] = 0; m_irq_en[i] = 0; m_shadow[i] = 0;
            end
            m_snapv = 0; m_cyc = 0; m_rd_data = 0; m_rd_ovf = 0; m_irq = 0;
            return;
        end
        // Registered outputs reflect the state seen just before this edge.
        idx = rd_idx;
        if (rd_shadow) m_rd_data = m_snapv ? m_shadow[idx] : 0;
        else           m_rd_data = m_val[idx];
        m_rd_ovf = m_ovf[idx];
        m_irq = 0;
        for (int i = 0; i < NC; i++) if (m_ovf[i] && m_irq_en[i]) m_irq = 1;

        if (!freeze) m_cyc = (m_cyc + 1) & CYC_MASK;

        for (int i = 0; i < NC; i++) begin
            if (cfg_we && cfg_idx == i) begin
                m_sel[i] = cfg_sel; m_en[i] = cfg_en; m_sat[i] = cfg_sat;
                m_irq_en[i] = cfg_irq_en; m_val[i] = 0; m_ovf[i] = 0;
            end else if (clr[i]) begin
                m_val[i] = 0; m_ovf[i] = 0;
            end else if (!freeze && m_en[i] && evt[m_sel[i]]) begin
                if (m_val[i] == CMAX) begin
                    m_ovf[i] = 1;
                    if (!m_sat[i]) m_val[i] = 0;
                end else begin
                    m_val[i] = m_val[i] + 1;
                end
            end
        end

        if (snap_req) begin
            for (int i = 0; i < NC; i++) m_shadow[i] = m_val[i];
            m_snapv = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle_count", cycle_count, m_cyc);
        chk("rd_data",     rd_data,     m_rd_data);
        chk("rd_ovf",      rd_ovf,      m_rd_ovf);
        chk("ovf_irq",     ovf_irq,     m_irq);
        chk("snap_valid",  snap_valid,  m_snapv);
    endtask

    task automatic configure(input int idx, input int sel, input bit en, input bit sat, input bit irq);
        cfg_idx = idx; cfg_sel = sel; cfg_en = en; cfg_sat = sat; cfg_irq_en = irq;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; evt = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0;
        cfg_en = 1'b0; cfg_sat = 1'b0; cfg_irq_en = 1'b0; clr = '0;
        freeze = 1'b0; snap_req = 1'b0; rd_idx = '0; rd_shadow = 1'b0;

        // Reset state
        tick();
        chk("rst_cycle", cycle_count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_snap_valid", snap_valid, 0);
        chk("rst_irq", ovf_irq, 0);
        rst = 1'b0;

        // cnt0 counts stall pulses
        configure(0, EVT_STALL, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            evt = 8'b0000_0010; tick();
            evt = '0;           tick();
        end
        rd_idx = 0; rd_shadow = 0; tick();
        chk("cnt0_five", rd_data, 5);
        for (int k = 1; k < NC; k++) begin
            rd_idx = k; tick();
            chk("cnt_other_zero", rd_data, 0);
        end

        // cnt1 saturates with irq, then clear
        configure(1, EVT_RETIRE, 1, 1, 1);
        evt = 8'b0000_0001;
        repeat (260) tick();
        evt = '0; rd_idx = 1; tick();
        chk("sat_value", rd_data, CMAX);
        chk("sat_ovf", rd_ovf, 1);
        chk("sat_irq", ovf_irq, 1);
        clr = 4'b0010; tick(); clr = '0;
        chk("clr_irq_still", ovf_irq, 1);
        tick();
        chk("clr_irq_drop", ovf_irq, 0);
        chk("clr_value", rd_data, 0);
        chk("clr_ovf", rd_ovf, 0);

        // cnt2 wraps after 257 events
        configure(2, EVT_FLUSH, 1, 0, 0);
        evt = 8'b0000_0100;
        repeat (257) tick();
        evt = '0; rd_idx = 2; tick();
        chk("wrap_value", rd_data, 1);
        chk("wrap_ovf", rd_ovf, 1);

        // freeze holds everything
        freeze = 1'b1; evt = '1;
        repeat (10) tick();
        chk("freeze_hold", rd_data, 1);
        freeze = 1'b0; evt = 8'b0000_0100; tick();
        evt = '0; tick();
        chk("freeze_resume", rd_data, 2);

        // snapshot coincident with 20th event
        configure(3, EVT_DM_RD, 1, 0, 0);
        for (int j = 1; j <= 20; j++) begin
            evt = 8'b0000_1000; snap_req = (j == 20); tick();
        end
        snap_req = 1'b0;
        repeat (3) tick();
        evt = '0; rd_idx = 3; rd_shadow = 1'b1; tick();
        chk("snap_shadow", rd_data, 20);
        chk("snap_valid_set", snap_valid, 1);
        rd_shadow = 1'b0; tick();
        chk("snap_live", rd_data, 23);

        // cfg_we beats clr and the coincident event
        cfg_idx = 0; cfg_sel = EVT_DM_WR; cfg_en = 1; cfg_sat = 1; cfg_irq_en = 0;
        cfg_we = 1'b1; clr = 4'b0001; evt = 8'b0001_0000; tick();
        cfg_we = 1'b0; clr = '0; evt = '0; rd_idx = 0; tick();
        chk("cfg_clears", rd_data, 0);
        evt = 8'b0001_0000; tick(); evt = '0; tick();
        chk("cfg_new_sel", rd_data, 1);

        // reset mid-count
        evt = '1; repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0; evt = '0;
        chk("midrst_cycle", cycle_count, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_snap", snap_valid, 0);
        chk("midrst_irq", ovf_irq, 0);

        // randomized traffic against the model
        repeat (1500) begin
            rst        = ($urandom_range(0, 199) == 0);
            evt        = NE'($urandom);
            cfg_we     = ($urandom_range(0, 7) == 0);
            cfg_idx    = 2'($urandom);
            cfg_sel    = 3'($urandom);
            cfg_en     = ($urandom_range(0, 3) != 0);
            cfg_sat    = 1'($urandom);
            cfg_irq_en = 1'($urandom);
            clr        = ($urandom_range(0, 15) == 0) ? NC'($urandom) : '0;
            freeze     = ($urandom_range(0, 7) == 0);
            snap_req   = ($urandom_range(0, 15) == 0);
            rd_idx     = 2'($urandom);
            rd_shadow  = 1'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
